// File: rtl/decoy_pkg.sv
// Shared constants for the decoy symbol receive path: window length,
// the four legal window patterns, symbol codes and FSM state encoding.
package decoy_pkg;

    localparam int unsigned SYM_LEN = 6;

    // Window patterns written w[0] (first sample) in the MSB .. w[5] in the LSB
    localparam logic [5:0] PAT_SYM00 = 6'b000000;
    localparam logic [5:0] PAT_SYM01 = 6'b111000;
    localparam logic [5:0] PAT_SYM10 = 6'b000111;
    localparam logic [5:0] PAT_SYM11 = 6'b111111;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

    localparam logic [2:0] PHASE_MAX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_SKIP = 2'b10,
        ST_RUN  = 2'b11
    } state_t;

    // Phase offsets beyond the last sample slot are treated as the last slot
    function automatic logic [2:0] clamp_phase(input logic [2:0] phase);
        if (phase > PHASE_MAX) begin
            return PHASE_MAX;
        end else begin
            return phase;
        end
    endfunction

endpackage

// File: rtl/decoy_window_classifier.sv
// Maps one complete 6-sample window onto its 2-bit decoy symbol.
// Purely combinational; anything that is not one of the four legal
// patterns reports symbol 00 with the error flag raised.
module decoy_window_classifier
    import decoy_pkg::*;
(
    input  logic [5:0] win,
    output logic [1:0] sym,
    output logic       err
);

    // Pattern lookup with an explicit illegal-pattern fallback
    always_comb begin
        sym = SYM_00;
        err = 1'b0;
        case (win)
            PAT_SYM00: begin sym = SYM_00; err = 1'b0; end
            PAT_SYM01: begin sym = SYM_01; err = 1'b0; end
            PAT_SYM10: begin sym = SYM_10; err = 1'b0; end
            PAT_SYM11: begin sym = SYM_11; err = 1'b0; end
            default:   begin sym = SYM_00; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/decoy_decoder.sv
// Decoy symbol decoder: aligns to the PPS-started symbol grid, collects
// one window of monitor samples per symbol, classifies it one cycle after
// the last sample and keeps lock state plus symbol/error statistics.
module decoy_decoder #(
    parameter int SYM_LEN   = decoy_pkg::SYM_LEN,
    parameter int LOCK_GOOD = 8,
    parameter int ERR_W     = 16
) (
    input  logic             clk240,
    input  logic             rstn_240,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             pps_i,
    input  logic [2:0]       phase_i,
    input  logic             pulse_i,
    output logic [1:0]       sym_o,
    output logic             sym_valid_o,
    output logic             sym_err_o,
    output logic             locked_o,
    output logic [31:0]      sym_cnt_o,
    output logic [ERR_W-1:0] err_cnt_o
);
    import decoy_pkg::*;

    localparam int               GOOD_W    = $clog2(LOCK_GOOD + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_GOOD);
    localparam logic [2:0]       LAST_SLOT = 3'(SYM_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    state_t            state_r;
    logic              pps_prev_r;
    logic [2:0]        skip_r;
    logic [2:0]        slot_r;
    logic [5:0]        win_r;
    logic              win_done_r;
    logic [GOOD_W-1:0] good_r;

    logic [1:0]        cls_sym_s;
    logic              cls_err_s;
    logic              strobe_s;
    logic [GOOD_W-1:0] good_next_s;

    // win_r holds a complete window in the cycle after its last sample
    decoy_window_classifier u_classifier (
        .win (win_r),
        .sym (cls_sym_s),
        .err (cls_err_s)
    );

    assign strobe_s    = win_done_r & enable_i;
    assign good_next_s = (good_r == GOOD_MAX) ? GOOD_MAX : good_r + GOOD_W'(1);

    // Alignment FSM, window shift register and registered symbol outputs
    always_ff @(posedge clk240 or negedge rstn_240) begin
        if (!rstn_240) begin
            state_r     <= ST_IDLE;
            pps_prev_r  <= 1'b0;
            skip_r      <= 3'd0;
            slot_r      <= 3'd0;
            win_r       <= 6'd0;
            win_done_r  <= 1'b0;
            sym_o       <= 2'b00;
            sym_err_o   <= 1'b0;
            sym_valid_o <= 1'b0;
        end else begin
            pps_prev_r  <= pps_i;
            sym_valid_o <= 1'b0;
            win_done_r  <= 1'b0;
            if (strobe_s) begin
                sym_o       <= cls_sym_s;
                sym_err_o   <= cls_err_s;
                sym_valid_o <= 1'b1;
            end
            if (!enable_i) begin
                // Dropping enable abandons the grid; a partial window is lost
                state_r <= ST_IDLE;
                skip_r  <= 3'd0;
                slot_r  <= 3'd0;
                win_r   <= 6'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        slot_r <= 3'd0;
                        win_r  <= 6'd0;
                        // A PPS already high at enable is not a usable edge
                        if (!pps_i) begin
                            state_r <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (pps_i && !pps_prev_r) begin
                            slot_r <= 3'd0;
                            win_r  <= 6'd0;
                            skip_r <= clamp_phase(phase_i);
                            if (clamp_phase(phase_i) == 3'd0) begin
                                state_r <= ST_RUN;
                            end else begin
                                state_r <= ST_SKIP;
                            end
                        end
                    end
                    ST_SKIP: begin
                        if (skip_r <= 3'd1) begin
                            skip_r  <= 3'd0;
                            slot_r  <= 3'd0;
                            state_r <= ST_RUN;
                        end else begin
                            skip_r <= skip_r - 3'd1;
                        end
                    end
                    ST_RUN: begin
                        // Later PPS edges are ignored; the grid is free-running
                        win_r <= {win_r[4:0], pulse_i};
                        if (slot_r == LAST_SLOT) begin
                            slot_r     <= 3'd0;
                            win_done_r <= 1'b1;
                        end else begin
                            slot_r <= slot_r + 3'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Lock tracking and symbol/error statistics, updated with the strobe
    always_ff @(posedge clk240 or negedge rstn_240) begin
        if (!rstn_240) begin
            good_r    <= '0;
            locked_o  <= 1'b0;
            sym_cnt_o <= 32'd0;
            err_cnt_o <= '0;
        end else if (clear_i) begin
            good_r    <= '0;
            locked_o  <= 1'b0;
            sym_cnt_o <= 32'd0;
            err_cnt_o <= '0;
        end else if (strobe_s) begin
            sym_cnt_o <= sym_cnt_o + 32'd1;
            if (cls_err_s) begin
                good_r   <= '0;
                locked_o <= 1'b0;
                if (err_cnt_o != ERR_MAX) begin
                    err_cnt_o <= err_cnt_o + ERR_W'(1);
                end
            end else begin
                good_r   <= good_next_s;
                locked_o <= (good_next_s == GOOD_MAX);
            end
        end else if (state_r == ST_IDLE) begin
            good_r   <= '0;
            locked_o <= 1'b0;
        end
    end

endmodule
